// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out MSB
// first on sdata, with sframe high for every valid bit. An optional idle gap
// of GAP cycles separates consecutive frames.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-high reset
//   load_valid - source presents a word on load_data
//   load_data  - parallel word, sampled only on accept
//   load_ready - block can accept a word this cycle
//   sdata      - serial data, MSB first, 0 when not framing
//   sframe     - high while sdata carries a valid bit
//   busy       - high in SHIFT or GAP
//   done       - one-cycle pulse alongside the last bit of a frame
module piso_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sdata,
  output logic             sframe,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int unsigned W_M1   = WIDTH - 1;
  localparam int unsigned GAP_M1 = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [4:0]  BIT_LD = W_M1[4:0];
  localparam logic [3:0]  GAP_LD = GAP_M1[3:0];

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [4:0]       r_bitcnt;
  logic [3:0]       r_gapcnt;
  logic             r_sdata;
  logic             r_sframe;
  logic             r_busy;
  logic             r_done;
  logic             r_load_ready;

  // Every output is computed for the state being entered, so each one is a
  // plain flop with no input-to-output combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_gapcnt     <= '0;
      r_sdata      <= 1'b0;
      r_sframe     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_valid) begin
            r_state      <= ST_SHIFT;
            r_shift      <= load_data;
            r_bitcnt     <= BIT_LD;
            r_sdata      <= load_data[WIDTH-1];
            r_sframe     <= 1'b1;
            r_busy       <= 1'b1;
            r_load_ready <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (r_bitcnt != 5'd0) begin
            r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
            r_bitcnt <= r_bitcnt - 5'd1;
            // Next bit is the one that becomes MSB after this shift.
            r_sdata  <= r_shift[WIDTH-2];
            if (r_bitcnt == 5'd1) begin
              r_done       <= 1'b1;
              r_load_ready <= (GAP == 0);
            end
          end else if (GAP != 0) begin
            r_state      <= ST_GAP;
            r_gapcnt     <= GAP_LD;
            r_shift      <= '0;
            r_sdata      <= 1'b0;
            r_sframe     <= 1'b0;
            r_load_ready <= 1'b0;
          end else if (load_valid) begin
            // Back-to-back reload: sframe stays high without a bubble.
            r_shift      <= load_data;
            r_bitcnt     <= BIT_LD;
            r_sdata      <= load_data[WIDTH-1];
            r_sframe     <= 1'b1;
            r_busy       <= 1'b1;
            r_load_ready <= 1'b0;
          end else begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_sdata      <= 1'b0;
            r_sframe     <= 1'b0;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
          end
        end

        ST_GAP: begin
          if (r_gapcnt == 4'd0) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
          end else begin
            r_gapcnt <= r_gapcnt - 4'd1;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_sdata      <= 1'b0;
          r_sframe     <= 1'b0;
          r_busy       <= 1'b0;
          r_load_ready <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready = r_load_ready;
  assign sdata      = r_sdata;
  assign sframe     = r_sframe;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_piso_tx.sv
module tb_piso_tx;

  logic clk = 1'b0;
  logic run = 1'b0;
  logic rst = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Instance A: WIDTH=8, GAP=1
  logic       a_valid = 1'b0;
  logic [7:0] a_data  = '0;
  logic       a_ready, a_sdata, a_sframe, a_busy, a_done;
  // Instance B: WIDTH=8, GAP=0
  logic       b_valid = 1'b0;
  logic [7:0] b_data  = '0;
  logic       b_ready, b_sdata, b_sframe, b_busy, b_done;
  // Instance C: WIDTH=4, GAP=3
  logic       c_valid = 1'b0;
  logic [3:0] c_data  = '0;
  logic       c_ready, c_sdata, c_sframe, c_busy, c_done;

  logic [7:0] rx;

  always begin
    #5;
    if (run) clk = ~clk;
  end

  piso_tx #(.WIDTH(8), .GAP(1)) u_a (
    .clk(clk), .rst(rst), .load_valid(a_valid), .load_data(a_data),
    .load_ready(a_ready), .sdata(a_sdata), .sframe(a_sframe),
    .busy(a_busy), .done(a_done));

  piso_tx #(.WIDTH(8), .GAP(0)) u_b (
    .clk(clk), .rst(rst), .load_valid(b_valid), .load_data(b_data),
    .load_ready(b_ready), .sdata(b_sdata), .sframe(b_sframe),
    .busy(b_busy), .done(b_done));

  piso_tx #(.WIDTH(4), .GAP(3)) u_c (
    .clk(clk), .rst(rst), .load_valid(c_valid), .load_data(c_data),
    .load_ready(c_ready), .sdata(c_sdata), .sframe(c_sframe),
    .busy(c_busy), .done(c_done));

  // Receiving shift register on the same clock, enabled by the frame strobe.
  always_ff @(posedge clk) begin
    if (a_sframe) rx <= {rx[6:0], a_sdata};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8/GAP=1 frame on instance A, including gap and loopback check.
  task automatic send_a(input logic [7:0] w);
    a_valid = 1'b1;
    a_data  = w;
    tick();
    a_valid = 1'b0;
    a_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk("a_sdata",  {31'd0, a_sdata},  {31'd0, w[7-i]});
      chk("a_sframe", {31'd0, a_sframe}, 32'd1);
      chk("a_busy",   {31'd0, a_busy},   32'd1);
      chk("a_ready",  {31'd0, a_ready},  32'd0);
      chk("a_done",   {31'd0, a_done},   (i == 7) ? 32'd1 : 32'd0);
      tick();
    end
    chk("a_loopback", {24'd0, rx}, {24'd0, w});
    chk("a_gap_busy",   {31'd0, a_busy},   32'd1);
    chk("a_gap_ready",  {31'd0, a_ready},  32'd0);
    chk("a_gap_sframe", {31'd0, a_sframe}, 32'd0);
    chk("a_gap_sdata",  {31'd0, a_sdata},  32'd0);
    chk("a_gap_done",   {31'd0, a_done},   32'd0);
    tick();
    chk("a_idle_ready", {31'd0, a_ready}, 32'd1);
    chk("a_idle_busy",  {31'd0, a_busy},  32'd0);
  endtask

  // One WIDTH=4/GAP=3 frame on instance C, starting in its first bit cycle.
  task automatic frame_c(input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      chk("c_sdata",  {31'd0, c_sdata},  {31'd0, w[3-i]});
      chk("c_sframe", {31'd0, c_sframe}, 32'd1);
      chk("c_ready",  {31'd0, c_ready},  32'd0);
      chk("c_done",   {31'd0, c_done},   (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    for (int g = 0; g < 3; g++) begin
      chk("c_gap_sframe", {31'd0, c_sframe}, 32'd0);
      chk("c_gap_busy",   {31'd0, c_busy},   32'd1);
      chk("c_gap_ready",  {31'd0, c_ready},  32'd0);
      tick();
    end
    chk("c_idle_ready", {31'd0, c_ready}, 32'd1);
    chk("c_idle_busy",  {31'd0, c_busy},  32'd0);
  endtask

  initial begin
    logic [15:0] bb;

    // Async reset with the clock stopped.
    #3 rst = 1'b1;
    #1;
    chk("rst_sdata",  {31'd0, a_sdata},  32'd0);
    chk("rst_sframe", {31'd0, a_sframe}, 32'd0);
    chk("rst_busy",   {31'd0, a_busy},   32'd0);
    chk("rst_done",   {31'd0, a_done},   32'd0);
    chk("rst_ready",  {31'd0, a_ready},  32'd1);
    chk("rst_ready_b", {31'd0, b_ready}, 32'd1);
    chk("rst_ready_c", {31'd0, c_ready}, 32'd1);
    #10 rst = 1'b0;
    run = 1'b1;
    tick();
    tick();

    // Single frame.
    send_a(8'hA5);

    // Back-to-back frames with GAP=0.
    bb = 16'h817E;
    b_valid = 1'b1;
    b_data  = 8'h81;
    tick();
    b_data = 8'h7E;
    for (int i = 0; i < 16; i++) begin
      chk("b_sframe", {31'd0, b_sframe}, 32'd1);
      chk("b_sdata",  {31'd0, b_sdata},  {31'd0, bb[15-i]});
      chk("b_done",   {31'd0, b_done},   (i == 7 || i == 15) ? 32'd1 : 32'd0);
      chk("b_ready",  {31'd0, b_ready},  (i == 7 || i == 15) ? 32'd1 : 32'd0);
      if (i == 15) b_valid = 1'b0;
      tick();
    end
    chk("b_end_sframe", {31'd0, b_sframe}, 32'd0);
    chk("b_end_busy",   {31'd0, b_busy},   32'd0);
    chk("b_end_ready",  {31'd0, b_ready},  32'd1);

    // Valid held while busy, GAP=3; data changes before accept are ignored.
    c_valid = 1'b1;
    c_data  = 4'h9;
    tick();
    c_data = 4'h5;
    frame_c(4'h9);
    chk("c_pre_accept_done", {31'd0, c_done}, 32'd0);
    // Reached only after the 5 above sat unaccepted through frame and gap.
    c_data = 4'hC;
    tick();
    c_data = 4'h3;
    frame_c(4'hC);
    tick();
    c_valid = 1'b0;
    c_data  = 4'hF;
    frame_c(4'h3);

    // Reset mid-frame.
    a_valid = 1'b1;
    a_data  = 8'hFF;
    tick();
    a_valid = 1'b0;
    a_data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      chk("abort_sdata", {31'd0, a_sdata}, 32'd1);
      tick();
    end
    #1 rst = 1'b1;
    #1;
    chk("abort_sframe", {31'd0, a_sframe}, 32'd0);
    chk("abort_busy",   {31'd0, a_busy},   32'd0);
    chk("abort_done",   {31'd0, a_done},   32'd0);
    chk("abort_ready",  {31'd0, a_ready},  32'd1);
    #1 rst = 1'b0;
    tick();
    chk("post_abort_done",   {31'd0, a_done},   32'd0);
    chk("post_abort_sframe", {31'd0, a_sframe}, 32'd0);
    send_a(8'h01);

    // Loopback words.
    send_a(8'h00);
    send_a(8'hFF);
    send_a(8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
